// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory-access stage: RV32I funct3
// encodings, FSM state encoding and the misalignment predicate.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Byte accesses never trap; halfwords need addr[0]=0; words (including
   // the reserved encodings, which behave as words) need addr[1:0]=0.
   function automatic logic is_misaligned(input logic [2:0] func3,
                                          input logic [1:0] addr_lo);
      case (func3)
         F3_LB, F3_LBU: is_misaligned = 1'b0;
         F3_LH, F3_LHU: is_misaligned = addr_lo[0];
         default:       is_misaligned = (addr_lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Store lane alignment: turns funct3 and the low address bits into byte
// enables and lane-replicated write data. Purely combinational.
module lsu_store_align
   import lsu_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep
);

   // Byte/halfword/word lane selection; reserved encodings fall to word.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      be        = 4'b1111;
      wdata_rep = wdata;
      case (func3)
         F3_SB: begin
            be        = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
         end
         F3_SH: begin
            be        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_mem_access.sv
// Memory-access stage of the load/store path. Accepts one access, runs a
// req/gnt/rvalid transaction on the data bus and returns lane-aligned
// (unextended) load data with a one-cycle completion pulse.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned
// halfword/word accesses without touching the bus.
module lsu_mem_access
   import lsu_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_we,
   input  logic [2:0]    in_func3,
   input  logic [AW-1:0] in_addr,
   input  logic [DW-1:0] in_wdata,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [AW-1:0] dmem_addr,
   output logic [3:0]    dmem_be,
   output logic [DW-1:0] dmem_wdata,
   input  logic          dmem_gnt,
   input  logic          dmem_rvalid,
   input  logic [DW-1:0] dmem_rdata,
   output logic          out_valid,
   output logic [DW-1:0] out_ld_data,
   output logic [2:0]    out_func3,
   output logic          out_misalign,
   output logic          stall
);

   state_t        state;
   logic          we_q;
   logic [2:0]    func3_q;
   logic [1:0]    addr_lo_q;
   logic          accept;
   logic          trap;
   logic [3:0]    be_n;
   logic [DW-1:0] wdata_n;

   lsu_store_align u_store_align (
      .func3     (in_func3),
      .addr_lo   (in_addr[1:0]),
      .wdata     (in_wdata),
      .be        (be_n),
      .wdata_rep (wdata_n)
   );

   assign in_ready  = (state == ST_IDLE);
   assign accept    = in_valid && in_ready;
   assign stall     = (state != ST_IDLE) || accept;
   assign out_func3 = func3_q;

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = is_misaligned(in_func3, in_addr[1:0]);
`else
   // Without the trap feature nothing is ever flagged, so out_misalign stays 0.
   assign trap = 1'b0;
`endif

   // Transaction FSM; bus fields are latched at acceptance so they stay
   // stable for the whole request regardless of upstream changes.
   // NOTE: state uses non-blocking assignments, and the async reset clears
   // every register so dmem_req drops the moment rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         we_q         <= 1'b0;
         func3_q      <= 3'b000;
         addr_lo_q    <= 2'b00;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_be      <= 4'b0000;
         dmem_wdata   <= '0;
         out_valid    <= 1'b0;
         out_ld_data  <= '0;
         out_misalign <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  we_q         <= in_we;
                  func3_q      <= in_func3;
                  addr_lo_q    <= in_addr[1:0];
                  dmem_we      <= in_we;
                  dmem_addr    <= {in_addr[AW-1:2], 2'b00};
                  dmem_be      <= in_we ? be_n : 4'b1111;
                  dmem_wdata   <= in_we ? wdata_n : '0;
                  out_misalign <= trap;
                  if (trap) begin
                     out_ld_data <= '0;
                     out_valid   <= 1'b1;
                     state       <= ST_DONE;
                  end else begin
                     dmem_req <= 1'b1;
                     state    <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (dmem_gnt) begin
                  dmem_req <= 1'b0;
                  state    <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (dmem_rvalid) begin
                  out_ld_data <= we_q ? '0 : (dmem_rdata >> {addr_lo_q, 3'b000});
                  out_valid   <= 1'b1;
                  state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Self-checking bench for lsu_mem_access: a directed/random driver acts as
// both the EX/MEM source and the data-memory bus; expected completions go
// into a scoreboard queue and are compared when out_valid pulses.
module tb_lsu_mem_access;
   import lsu_pkg::*;

   typedef struct packed {
      logic [31:0] ld;
      logic [2:0]  f3;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_we;
   logic [2:0]  in_func3;
   logic [31:0] in_addr, in_wdata;
   logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        out_valid, out_misalign, stall;
   logic [31:0] out_ld_data;
   logic [2:0]  out_func3;

   exp_t sb_q[$];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   ov_count = 0;

   logic [2:0] ld_f3 [5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
   logic [2:0] st_f3 [4] = '{F3_SB, F3_SH, F3_SW, 3'b011};

   lsu_mem_access #(.AW(32), .DW(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_we        (in_we),
      .in_func3     (in_func3),
      .in_addr      (in_addr),
      .in_wdata     (in_wdata),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_be      (dmem_be),
      .dmem_wdata   (dmem_wdata),
      .dmem_gnt     (dmem_gnt),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_rdata   (dmem_rdata),
      .out_valid    (out_valid),
      .out_ld_data  (out_ld_data),
      .out_func3    (out_func3),
      .out_misalign (out_misalign),
      .stall        (stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model of the store lanes and the misalignment rule.
   function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [1:0] a);
      if (!we)                m_be = 4'b1111;
      else if (f3 == 3'b000)  m_be = (a == 2'd0) ? 4'b0001 : (a == 2'd1) ? 4'b0010 :
                                     (a == 2'd2) ? 4'b0100 : 4'b1000;
      else if (f3 == 3'b001)  m_be = a[1] ? 4'b1100 : 4'b0011;
      else                    m_be = 4'b1111;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (f3 == 3'b000)      m_wdata = {d[7:0], d[7:0], d[7:0], d[7:0]};
      else if (f3 == 3'b001) m_wdata = {d[15:0], d[15:0]};
      else                   m_wdata = d;
   endfunction

   function automatic logic m_mis(input logic [2:0] f3, input logic [1:0] a);
      if (f3 == 3'b000 || f3 == 3'b100)      m_mis = 1'b0;
      else if (f3 == 3'b001 || f3 == 3'b101) m_mis = a[0];
      else                                   m_mis = (a != 2'd0);
   endfunction

   // Completion monitor: every out_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid) begin
         ov_count++;
         if (sb_q.size() == 0) begin
            check("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("out_ld_data", out_ld_data, e.ld);
            check("out_func3", 32'(out_func3), 32'(e.f3));
            check("out_misalign", 32'(out_misalign), 32'(e.mis));
         end
      end
   end

   // One access: accept in cycle 0, grant after gnt_dly wait cycles,
   // response rv_dly cycles after the cycle following grant.
   task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int gnt_dly, input int rv_dly, input bit noise);
      exp_t e;
      logic mis;
      mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis = m_mis(f3, addr[1:0]);
`endif
      e.ld  = (we || mis) ? 32'd0 : (rdata >> (8 * addr[1:0]));
      e.f3  = f3;
      e.mis = mis;
      in_valid = 1'b1;
      in_we    = we;
      in_func3 = f3;
      in_addr  = addr;
      in_wdata = wdata;
      @(negedge clk);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      check("stall_on_accept", 32'(stall), 32'd1);
      check("no_out_valid_idle", 32'(out_valid), 32'd0);
      sb_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_addr  = $urandom;
      in_wdata = $urandom;
      if (mis) begin
         @(negedge clk);
         check("trap_no_req", 32'(dmem_req), 32'd0);
         check("trap_out_valid_c1", 32'(out_valid), 32'd1);
         @(posedge clk); #1;
         return;
      end
      for (int i = 0; i <= gnt_dly; i++) begin
         dmem_gnt    = (i == gnt_dly);
         dmem_rvalid = noise && (i < gnt_dly);
         dmem_rdata  = $urandom;
         @(negedge clk);
         check("req_held", 32'(dmem_req), 32'd1);
         check("stall_req", 32'(stall), 32'd1);
         check("in_ready_busy", 32'(in_ready), 32'd0);
         if (i == gnt_dly) begin
            check("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
            check("dmem_we", 32'(dmem_we), 32'(we));
            check("dmem_be", 32'(dmem_be), 32'(m_be(we, f3, addr[1:0])));
            if (we) check("dmem_wdata", dmem_wdata, m_wdata(f3, wdata));
         end
         @(posedge clk); #1;
      end
      dmem_gnt = 1'b0;
      for (int i = 0; i <= rv_dly; i++) begin
         dmem_rvalid = (i == rv_dly);
         dmem_rdata  = (i == rv_dly) ? rdata : $urandom;
         @(negedge clk);
         check("req_low_resp", 32'(dmem_req), 32'd0);
         check("stall_resp", 32'(stall), 32'd1);
         check("no_out_valid_resp", 32'(out_valid), 32'd0);
         @(posedge clk); #1;
      end
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      @(negedge clk);
      check("out_valid_done", 32'(out_valid), 32'd1);
      check("stall_done", 32'(stall), 32'd1);
      @(posedge clk); #1;
   endtask

   // Start a load, then pull rst_n low in REQ or RESP.
   task automatic reset_mid(input bit in_resp);
      int base;
      in_valid = 1'b1;
      in_we    = 1'b0;
      in_func3 = F3_LW;
      in_addr  = 32'h0000_0300;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (in_resp) begin
         dmem_gnt = 1'b1;
         @(posedge clk); #1;
         dmem_gnt = 1'b0;
         check("rst_pre_busy", 32'(in_ready), 32'd0);
      end else begin
         check("rst_pre_req", 32'(dmem_req), 32'd1);
      end
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_req", 32'(dmem_req), 32'd0);
      check("rst_async_ready", 32'(in_ready), 32'd1);
      check("rst_async_stall", 32'(stall), 32'd0);
      base = ov_count;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h1234_5678;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("rst_no_out_valid", 32'(ov_count), 32'(base));
      check("rst_ready_after", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_we       = 1'b0;
      in_func3    = 3'b000;
      in_addr     = 32'd0;
      in_wdata    = 32'd0;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'd0;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_dmem_req", 32'(dmem_req), 32'd0);
      check("rst_dmem_we", 32'(dmem_we), 32'd0);
      check("rst_dmem_be", 32'(dmem_be), 32'd0);
      check("rst_dmem_addr", dmem_addr, 32'd0);
      check("rst_dmem_wdata", dmem_wdata, 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_ld_data", out_ld_data, 32'd0);
      check("rst_out_func3", 32'(out_func3), 32'd0);
      check("rst_out_misalign", 32'(out_misalign), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_access(1'b0, F3_LW,  32'h0000_0100, 32'd0,         32'hDEAD_BEEF, 0, 0, 1'b0);
      do_access(1'b0, F3_LBU, 32'h0000_0103, 32'd0,         32'h8011_2233, 0, 0, 1'b0);
      do_access(1'b1, F3_SB,  32'h0000_0102, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 0, 1'b0);
      do_access(1'b0, F3_LW,  32'h0000_0200, 32'd0,         32'h0BAD_F00D, 3, 2, 1'b1);
      do_access(1'b1, F3_SH,  32'h0000_0206, 32'h1234_BEEF, 32'd0,         1, 0, 1'b0);
      do_access(1'b0, F3_LH,  32'h0000_0102, 32'd0,         32'hCAFE_1234, 0, 1, 1'b0);
      do_access(1'b1, 3'b011, 32'h0000_010C, 32'h5566_7788, 32'd0,         0, 0, 1'b0);
      do_access(1'b0, F3_LW,  32'h0000_0102, 32'd0,         32'hA1B2_C3D4, 0, 0, 1'b0);
      do_access(1'b1, F3_SW,  32'h0000_0101, 32'hCAFE_D00D, 32'd0,         0, 0, 1'b0);

      for (int k = 0; k < 12; k++) begin
         logic        we;
         logic [2:0]  f3;
         we = 1'($urandom_range(0, 1));
         f3 = we ? st_f3[$urandom_range(0, 3)] : ld_f3[$urandom_range(0, 4)];
         do_access(we, f3, $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      reset_mid(1'b0);
      reset_mid(1'b1);
      do_access(1'b0, F3_LB, 32'h0000_0401, 32'd0, 32'h7766_5544, 0, 0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
